// File: rtl/regfile_32x32.sv
// -----------------------------------------------------------------------------
// regfile_32x32
//
// 32-entry x 32-bit architectural register file for the RISC core.
// One synchronous write port, driven by the one-hot select vector produced by
// the 5-to-32 write-address decoder, and two asynchronous read ports. Each
// read port decodes its 5-bit index to one-hot with the same decoder structure
// and selects through an AND-OR mux. Register 0 is hardwired to zero.
//
// Ports:
//   clock             in   1      system clock, rising-edge active
//   ctrl_reset        in   1      synchronous, active-high reset
//   ctrl_writeEnable  in   1      global write enable from writeback
//   ctrl_writeSel     in   NREGS  one-hot write select (bit i -> reg i)
//   ctrl_readRegA     in   5      read port A index
//   ctrl_readRegB     in   5      read port B index
//   data_writeReg     in   WIDTH  write data
//   data_readRegA     out  WIDTH  contents of reg ctrl_readRegA
//   data_readRegB     out  WIDTH  contents of reg ctrl_readRegB
//   err_selInvalid    out  1      registered: previous edge saw an enabled
//                                 write with more than one select bit set
//
// Optional feature macro: REGFILE_BYPASS_EN
//   When defined, a legal write to register k (k != 0) is forwarded
//   combinationally to any read port addressing k in the same cycle.
//   When undefined, reads show the stored value only.
// -----------------------------------------------------------------------------
module regfile_32x32 #(
   parameter int WIDTH = 32,
   parameter int NREGS = 32
) (
   input  logic             clock,
   input  logic             ctrl_reset,
   input  logic             ctrl_writeEnable,
   input  logic [NREGS-1:0] ctrl_writeSel,
   input  logic [4:0]       ctrl_readRegA,
   input  logic [4:0]       ctrl_readRegB,
   input  logic [WIDTH-1:0] data_writeReg,
   output logic [WIDTH-1:0] data_readRegA,
   output logic [WIDTH-1:0] data_readRegB,
   output logic             err_selInvalid
);

   localparam int AW = 5;

   // Register 0 has no storage; only 1..NREGS-1 are flops.
   logic [WIDTH-1:0] r_regs [1:NREGS-1];
   logic             r_err;

   logic             w_sel_multi;
   logic             w_write_ok;
   logic [NREGS-1:0] w_onehot_a;
   logic [NREGS-1:0] w_onehot_b;
   logic [WIDTH-1:0] w_reg_view [0:NREGS-1];
   logic [WIDTH-1:0] w_stored_a;
   logic [WIDTH-1:0] w_stored_b;

   // 5-to-32 one-hot decoder, same structure as the write-address decoder.
   function automatic logic [NREGS-1:0] f_decode(input logic [AW-1:0] idx);
      logic [NREGS-1:0] v;
      v = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // x & (x-1) clears the lowest set bit; anything left means two or more
   // bits were set. All-zero and exactly-one-hot both come out legal.
   assign w_sel_multi = |(ctrl_writeSel & (ctrl_writeSel - NREGS'(1)));

   // An illegal select suppresses the whole write, not just the extra bits.
   // An unknown select makes this unknown, and the if() below then writes
   // nothing, so X never spreads into unselected registers.
   assign w_write_ok = ctrl_writeEnable & ~w_sel_multi & ~ctrl_reset;

   always_ff @(posedge clock) begin
      if (ctrl_reset) begin
         for (int i = 1; i < NREGS; i++) begin
            r_regs[i] <= '0;
         end
         r_err <= 1'b0;
      end else begin
         r_err <= ctrl_writeEnable & w_sel_multi;
         for (int i = 1; i < NREGS; i++) begin
            if (w_write_ok && ctrl_writeSel[i]) begin
               r_regs[i] <= data_writeReg;
            end
         end
      end
   end

   assign err_selInvalid = r_err;

   // Flat view of the architectural state with register 0 tied to zero, so
   // the read mux can treat all 32 indices uniformly.
   always_comb begin
      w_reg_view[0] = '0;
      for (int i = 1; i < NREGS; i++) begin
         w_reg_view[i] = r_regs[i];
      end
   end

   assign w_onehot_a = f_decode(ctrl_readRegA);
   assign w_onehot_b = f_decode(ctrl_readRegB);

   // AND-OR read mux: each entry is gated by its decoded select bit.
   always_comb begin
      w_stored_a = '0;
      w_stored_b = '0;
      for (int i = 0; i < NREGS; i++) begin
         w_stored_a = w_stored_a | ({WIDTH{w_onehot_a[i]}} & w_reg_view[i]);
         w_stored_b = w_stored_b | ({WIDTH{w_onehot_b[i]}} & w_reg_view[i]);
      end
   end

`ifdef REGFILE_BYPASS_EN
   logic w_byp_a;
   logic w_byp_b;

   // Forward only a write that will really land: legal, enabled, not in
   // reset, and aimed at a nonzero register the port is reading. Bit 0 is
   // masked off so register 0 is never forwarded.
   assign w_byp_a = w_write_ok & (|(w_onehot_a[NREGS-1:1] & ctrl_writeSel[NREGS-1:1]));
   assign w_byp_b = w_write_ok & (|(w_onehot_b[NREGS-1:1] & ctrl_writeSel[NREGS-1:1]));

   assign data_readRegA = w_byp_a ? data_writeReg : w_stored_a;
   assign data_readRegB = w_byp_b ? data_writeReg : w_stored_b;
`else
   assign data_readRegA = w_stored_a;
   assign data_readRegB = w_stored_b;
`endif

endmodule

// File: tb/tb_regfile_32x32.sv
// -----------------------------------------------------------------------------
// tb_regfile_32x32
//
// Self-checking bench for regfile_32x32. Inputs change on the falling edge;
// outputs are sampled 2 ns later, i.e. before the next rising edge, so read
// ports show the state left by the previous rising edge and err_selInvalid
// shows the flag registered on that edge.
// -----------------------------------------------------------------------------
module tb_regfile_32x32;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic        clock;
   logic        ctrl_reset;
   logic        ctrl_writeEnable;
   logic [31:0] ctrl_writeSel;
   logic [4:0]  ctrl_readRegA;
   logic [4:0]  ctrl_readRegB;
   logic [31:0] data_writeReg;
   logic [31:0] data_readRegA;
   logic [31:0] data_readRegB;
   logic        err_selInvalid;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   regfile_32x32 #(.WIDTH(32), .NREGS(32)) dut (
      .clock            (clock),
      .ctrl_reset       (ctrl_reset),
      .ctrl_writeEnable (ctrl_writeEnable),
      .ctrl_writeSel    (ctrl_writeSel),
      .ctrl_readRegA    (ctrl_readRegA),
      .ctrl_readRegB    (ctrl_readRegB),
      .data_writeReg    (data_writeReg),
      .data_readRegA    (data_readRegA),
      .data_readRegB    (data_readRegB),
      .err_selInvalid   (err_selInvalid)
   );

   // ---------------- scoreboard ----------------
   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // ---------------- vector table ----------------
   // exp_* are the read values without forwarding, byp_* with forwarding.
   typedef struct {
      logic        rst;
      logic        we;
      logic [31:0] sel;
      logic [31:0] data;
      logic [4:0]  ra;
      logic [4:0]  rb;
      logic [31:0] exp_a;
      logic [31:0] exp_b;
      logic [31:0] byp_a;
      logic [31:0] byp_b;
      logic        exp_err;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic rst, input logic we, input logic [31:0] sel,
                               input logic [31:0] data, input logic [4:0] ra, input logic [4:0] rb,
                               input logic [31:0] exp_a, input logic [31:0] exp_b,
                               input logic [31:0] byp_a, input logic [31:0] byp_b,
                               input logic exp_err);
      vec_t v;
      v.rst = rst; v.we = we; v.sel = sel; v.data = data; v.ra = ra; v.rb = rb;
      v.exp_a = exp_a; v.exp_b = exp_b; v.byp_a = byp_a; v.byp_b = byp_b; v.exp_err = exp_err;
      return v;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive(input logic rst, input logic we, input logic [31:0] sel,
                        input logic [31:0] data, input logic [4:0] ra, input logic [4:0] rb);
      @(negedge clock);
      ctrl_reset       = rst;
      ctrl_writeEnable = we;
      ctrl_writeSel    = sel;
      data_writeReg    = data;
      ctrl_readRegA    = ra;
      ctrl_readRegB    = rb;
      #2;
   endtask

   task automatic do_reset();
      drive(1'b1, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0);
      drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0);
   endtask

   // ---------------- test ----------------
   initial begin
      ctrl_reset = 1'b1; ctrl_writeEnable = 1'b0; ctrl_writeSel = '0;
      data_writeReg = '0; ctrl_readRegA = '0; ctrl_readRegB = '0;

      //        rst we  sel           data          ra  rb  exp_a         exp_b         byp_a         byp_b         err
      vecs.push_back(mk(0, 0, 32'h0,        32'h0,        5,  5,  32'h0,        32'h0,        32'h0,        32'h0,        0)); // reset state
      vecs.push_back(mk(0, 1, 32'h00000020, 32'hDEADBEEF, 5,  5,  32'h0,        32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 0)); // write r5
      vecs.push_back(mk(0, 0, 32'h0,        32'h0,        5,  5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 0));
      vecs.push_back(mk(0, 1, 32'h00000001, 32'hFFFFFFFF, 0,  5,  32'h0,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 0)); // write r0
      vecs.push_back(mk(0, 0, 32'h0,        32'h0,        0,  5,  32'h0,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 0));
      vecs.push_back(mk(0, 1, 32'h00000002, 32'h11111111, 1,  2,  32'h0,        32'h0,        32'h11111111, 32'h0,        0)); // r1
      vecs.push_back(mk(0, 1, 32'h00000004, 32'h22222222, 1,  2,  32'h11111111, 32'h0,        32'h11111111, 32'h22222222, 0)); // r2
      vecs.push_back(mk(0, 1, 32'h00000006, 32'h12345678, 1,  2,  32'h11111111, 32'h22222222, 32'h11111111, 32'h22222222, 0)); // illegal
      vecs.push_back(mk(0, 1, 32'h00000008, 32'h33333333, 1,  2,  32'h11111111, 32'h22222222, 32'h11111111, 32'h22222222, 1)); // flag up, legal write
      vecs.push_back(mk(0, 0, 32'h0,        32'h0,        3,  3,  32'h33333333, 32'h33333333, 32'h33333333, 32'h33333333, 0)); // flag cleared
      vecs.push_back(mk(0, 1, 32'hFFFFFFFF, 32'h0,        3,  5,  32'h33333333, 32'hDEADBEEF, 32'h33333333, 32'hDEADBEEF, 0)); // all-ones illegal
      vecs.push_back(mk(0, 0, 32'h00000030, 32'hAAAAAAAA, 3,  5,  32'h33333333, 32'hDEADBEEF, 32'h33333333, 32'hDEADBEEF, 1)); // multi-bit, we=0
      vecs.push_back(mk(0, 0, 32'h0,        32'h0,        4,  5,  32'h0,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 0)); // no flag for we=0
      vecs.push_back(mk(1, 1, 32'h80000000, 32'hA5A5A5A5, 31, 5,  32'h0,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 0)); // reset vs write
      vecs.push_back(mk(0, 0, 32'h0,        32'h0,        31, 5,  32'h0,        32'h0,        32'h0,        32'h0,        0));
      vecs.push_back(mk(0, 1, 32'h0,        32'h77777777, 0,  1,  32'h0,        32'h0,        32'h0,        32'h0,        0)); // zero select
      vecs.push_back(mk(0, 0, 32'h0,        32'h0,        1,  0,  32'h0,        32'h0,        32'h0,        32'h0,        0));

      do_reset();

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].we, vecs[i].sel, vecs[i].data, vecs[i].ra, vecs[i].rb);
         check($sformatf("vec%0d_rdA", i), data_readRegA, BYP ? vecs[i].byp_a : vecs[i].exp_a);
         check($sformatf("vec%0d_rdB", i), data_readRegB, BYP ? vecs[i].byp_b : vecs[i].exp_b);
         check($sformatf("vec%0d_err", i), {31'h0, err_selInvalid}, {31'h0, vecs[i].exp_err});
      end

      // Sweep: r[i] = i * 0x01010101, then read every pair (i, 31-i).
      for (int i = 1; i < 32; i++) begin
         drive(1'b0, 1'b1, 32'h1 << i, i * 32'h01010101, 5'd0, 5'd0);
      end
      for (int i = 0; i < 32; i++) begin
         exp_q.push_back(i * 32'h01010101);
         exp_q.push_back((31 - i) * 32'h01010101);
      end
      for (int i = 0; i < 32; i++) begin
         logic [31:0] ea;
         logic [31:0] eb;
         drive(1'b0, 1'b0, 32'h0, 32'h0, 5'(i), 5'(31 - i));
         ea = exp_q.pop_front();
         eb = exp_q.pop_front();
         check($sformatf("sweep_A%0d", i), data_readRegA, ea);
         check($sformatf("sweep_B%0d", 31 - i), data_readRegB, eb);
      end

      // Random writes, an illegal select, then a single reset edge.
      for (int i = 0; i < 8; i++) begin
         logic [31:0] s;
         s = ($urandom_range(0, 3) == 0) ? $urandom : (32'h1 << $urandom_range(1, 31));
         drive(1'b0, 1'b1, s, $urandom, 5'd0, 5'd0);
      end
      drive(1'b0, 1'b1, 32'h00000006, 32'h12345678, 5'd0, 5'd0);
      drive(1'b1, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0);
      check("err_before_reset_edge", {31'h0, err_selInvalid}, 32'h1);
      for (int i = 0; i < 32; i++) begin
         drive(1'b0, 1'b0, 32'h0, 32'h0, 5'(i), 5'(31 - i));
         check($sformatf("post_reset_A%0d", i), data_readRegA, 32'h0);
         check($sformatf("post_reset_B%0d", 31 - i), data_readRegB, 32'h0);
         if (i == 0) check("post_reset_err", {31'h0, err_selInvalid}, 32'h0);
      end

      // ---------------- report ----------------
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_32x32.md
Name: regfile_32x32

Overview:
- 32-entry × 32-bit architectural register file for the RISC core.
- Consumes the one-hot write-select vector produced by the team's 5-to-32 write-address decoder. Reuses the same decoder structure internally for read-port selection.
- Sits between the decode/writeback stages: one synchronous write port and two asynchronous read ports.
- Register 0 is hardwired to zero.

Parameters:
- WIDTH, 32, data width of each register and of all data ports.
- NREGS, 32, number of architectural registers; fixed at 32 to match the 5-bit address and 32-bit one-hot select.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- ctrl_reset  in  1  reset, synchronous, active-high.
- ctrl_writeEnable  in  1  global write enable from the writeback stage.
- ctrl_writeSel  in  32  one-hot write-register select from the 5-to-32 decoder; bit i selects register i.
- ctrl_readRegA  in  5  read port A register index.
- ctrl_readRegB  in  5  read port B register index.
- data_writeReg  in  WIDTH  write data.
- data_readRegA  out  WIDTH  contents of register ctrl_readRegA.
- data_readRegB  out  WIDTH  contents of register ctrl_readRegB.
- err_selInvalid  out  1  registered flag: the last cycle carried an illegal write select.

Behaviour:
- Clock and reset: one clock, "clock". Reset "ctrl_reset" is synchronous and active-high; it takes effect only on a rising edge of clock while asserted.
- Reset:
  - On a clock edge with ctrl_reset=1, all registers 1..31 become 0 and err_selInvalid becomes 0.
  - Reset has priority over a simultaneous write; the write is dropped.
- Write:
  - On a rising edge with ctrl_reset=0 and ctrl_writeEnable=1, register i (i≠0) loads data_writeReg for each set bit ctrl_writeSel[i].
  - Writes to register 0 are silently discarded; register 0 always reads 0.
- Write-select legality:
  - Legal ctrl_writeSel is exactly one bit set, or all zero.
  - All zero with ctrl_writeEnable=1 means no register is written.
  - More than one bit set with ctrl_writeEnable=1 means no register is written (the write is suppressed entirely), and err_selInvalid=1 on the next edge.
  - err_selInvalid is otherwise 0 on the next edge; it is a one-cycle, per-edge registered flag.
- Read:
  - Both read ports are combinational from the register array, with a 0-cycle latency to the stored value.
  - Each port decodes its 5-bit index to one-hot and selects via AND-OR tristate-free muxing.
  - ctrl_readRegA == ctrl_readRegB is legal; both ports return the same value.
- Read-during-write, without the optional feature: a read returns the pre-edge value in the write cycle and the new value after the edge.
- Output reset values: data_readRegA and data_readRegB read 0 for every index after reset. err_selInvalid=0.
- Reset mid-operation: any pending write in the reset cycle is lost. Reads during the reset cycle still show the old contents until the edge.
- No X propagation: an unknown write select must not corrupt registers other than those actually selected. Simulation must initialise via reset before use.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding.
  - If ctrl_writeEnable=1, ctrl_reset=0, ctrl_writeSel is legal one-hot with bit k set, k≠0, and ctrl_readRegA (or B) == k, then that port outputs data_writeReg combinationally in the same cycle.
  - Register 0 is never bypassed.
  - Illegal selects and reset are never bypassed.
- Undefined: no forwarding; reads show the stored value only, as described in Behaviour.

Test Plan:
- Reset: assert ctrl_reset for 1 edge after random writes → all 32 indices read 0x00000000 on both ports; err_selInvalid=0.
- Basic write/read: write 0xDEADBEEF with ctrl_writeSel=0x00000020 (reg 5), then read A=5, B=5 → both 0xDEADBEEF next cycle. In the write cycle, without the macro the ports show the old value; with REGFILE_BYPASS_EN they show 0xDEADBEEF.
- Register zero: write 0xFFFFFFFF with ctrl_writeSel=0x00000001 → read A=0 returns 0x00000000. Not bypassed even with the macro.
- Illegal select: ctrl_writeSel=0x00000006, ctrl_writeEnable=1, data=0x12345678 → regs 1 and 2 unchanged; err_selInvalid=1 for exactly one cycle; a following legal write clears it.
- Reset versus write collision: ctrl_reset=1 with ctrl_writeEnable=1, ctrl_writeSel=0x80000000, data=0xA5A5A5A5 → reg 31 reads 0 after the edge.
- Sweep: write value i*0x01010101 to each reg i=1..31 on successive cycles, then read all index pairs (i, 31-i) → exact values, reg 0 = 0, no aliasing.
